// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: frame-generator state encoding, frame-size limits
// and the MAC address type.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        PAYLOAD = 3'd2,
        GAP     = 3'd3,
        DONE    = 3'd4
    } tx_gen_state_t;

    localparam int ETH_HDR_LEN     = 14;
    localparam int ETH_MIN_PAYLOAD = 46;
    localparam int ETH_MAX_PAYLOAD = 1500;

    typedef logic [47:0] mac_addr_t;

endpackage

// File: rtl/eth_tx_frame_gen.sv
// AXI-stream Ethernet frame generator: 14-byte header plus counting payload, one byte/cycle.
// Define ETH_TX_GEN_SEQNUM_EN to replace payload bytes 0-1 with a per-run frame sequence number.
module eth_tx_frame_gen
    import eth_pkg::*;
#(
    parameter int          PAYLOAD_LEN = 46,
    parameter int          GAP_CYCLES  = 12,
    parameter mac_addr_t   DST_MAC     = 48'hFFFF_FFFF_FFFF,
    parameter mac_addr_t   SRC_MAC     = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic [15:0] i_frame_count,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_trdy,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_frames_sent
);

    localparam logic [10:0] PAY_START = 11'(ETH_HDR_LEN);
    localparam logic [10:0] LAST_IDX  = 11'(ETH_HDR_LEN + PAYLOAD_LEN - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

    tx_gen_state_t state;
    logic [10:0]   byte_cnt;
    logic [10:0]   load_idx;
    logic [7:0]    load_byte;
    logic [15:0]   gap_cnt;
    logic [15:0]   frame_target;
`ifdef ETH_TX_GEN_SEQNUM_EN
    logic [15:0]   seq_num;
`endif

    // Byte at frame offset idx (header region first, then the k[7:0] payload pattern).
    function automatic logic [7:0] frame_byte(input logic [10:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (idx >= PAY_START) begin
            b = idx[7:0] - 8'(ETH_HDR_LEN);
        end else begin
            case (idx[3:0])
                4'd0:    b = DST_MAC[47:40];
                4'd1:    b = DST_MAC[39:32];
                4'd2:    b = DST_MAC[31:24];
                4'd3:    b = DST_MAC[23:16];
                4'd4:    b = DST_MAC[15:8];
                4'd5:    b = DST_MAC[7:0];
                4'd6:    b = SRC_MAC[47:40];
                4'd7:    b = SRC_MAC[39:32];
                4'd8:    b = SRC_MAC[31:24];
                4'd9:    b = SRC_MAC[23:16];
                4'd10:   b = SRC_MAC[15:8];
                4'd11:   b = SRC_MAC[7:0];
                4'd12:   b = ETHERTYPE[15:8];
                4'd13:   b = ETHERTYPE[7:0];
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

    // Offset of the byte to present next: restart at 0 out of GAP, else advance past an accepted byte.
    always_comb begin
        load_idx = 11'd0;
        if (state != GAP) begin
            load_idx = m_axis_tvalid ? byte_cnt + 11'd1 : byte_cnt;
        end
        load_byte = frame_byte(load_idx);
`ifdef ETH_TX_GEN_SEQNUM_EN
        if (load_idx == PAY_START) begin
            load_byte = seq_num[15:8];
        end else if (load_idx == PAY_START + 11'd1) begin
            load_byte = seq_num[7:0];
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= IDLE;
            byte_cnt      <= 11'd0;
            gap_cnt       <= 16'd0;
            frame_target  <= 16'd0;
            m_axis_tdata  <= 8'h00;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_frames_sent <= 16'd0;
`ifdef ETH_TX_GEN_SEQNUM_EN
            seq_num       <= 16'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_enable) begin
                        state         <= HEADER;
                        frame_target  <= i_frame_count;
                        o_frames_sent <= 16'd0;
                        byte_cnt      <= 11'd0;
                        o_busy        <= 1'b1;
`ifdef ETH_TX_GEN_SEQNUM_EN
                        seq_num       <= 16'd0;
`endif
                    end
                end

                HEADER, PAYLOAD: begin
                    // Output register only reloads when empty or its byte was accepted.
                    if (!m_axis_tvalid || m_axis_trdy) begin
                        if (m_axis_tvalid && m_axis_tlast) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            o_frames_sent <= o_frames_sent + 16'd1;
                            gap_cnt       <= 16'd0;
                            state         <= GAP;
`ifdef ETH_TX_GEN_SEQNUM_EN
                            seq_num       <= seq_num + 16'd1;
`endif
                        end else begin
                            m_axis_tdata  <= load_byte;
                            m_axis_tvalid <= 1'b1;
                            m_axis_tlast  <= (load_idx == LAST_IDX);
                            byte_cnt      <= load_idx;
                            state         <= (load_idx >= PAY_START) ? PAYLOAD : HEADER;
                        end
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (frame_target != 16'd0 && o_frames_sent == frame_target) begin
                            state  <= DONE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end else if (!i_enable) begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            // Preload byte 0 so the idle gap is exactly GAP_CYCLES long.
                            state         <= HEADER;
                            byte_cnt      <= load_idx;
                            m_axis_tdata  <= load_byte;
                            m_axis_tvalid <= 1'b1;
                            m_axis_tlast  <= (load_idx == LAST_IDX);
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end

                DONE: begin
                    if (!i_enable) begin
                        state  <= IDLE;
                        o_done <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_frame_gen.sv
// Self-checking bench for eth_tx_frame_gen: directed runs plus random back-pressure,
// checked against a frame model built from the header constants and payload rule.
module tb_eth_tx_frame_gen;
    import eth_pkg::*;

    localparam int          PL  = 46;
    localparam int          GAP = 12;
    localparam int          FL  = ETH_HDR_LEN + PL;
    localparam logic [47:0] DST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC = 48'h02_00_00_00_00_01;
    localparam logic [15:0] ET  = 16'h88B5;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic [15:0] i_frame_count;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_trdy;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_frames_sent;

    eth_tx_frame_gen #(
        .PAYLOAD_LEN (PL),
        .GAP_CYCLES  (GAP),
        .DST_MAC     (DST),
        .SRC_MAC     (SRC),
        .ETHERTYPE   (ET)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_enable      (i_enable),
        .i_frame_count (i_frame_count),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_trdy   (m_axis_trdy),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_frames_sent (o_frames_sent)
    );

    always #5 i_clk = ~i_clk;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          rdy_mode;
    int          done_cyc;
    int          en_cyc;
    logic [7:0]  cap_d[$];
    logic        cap_l[$];
    int          last_cyc[$];
    int          start_cyc[$];
    logic [15:0] fs_after[$];
    logic        hs_last_prev;
    logic        stall_pending;
    logic        prev_vld;
    logic [9:0]  held;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected byte idx of the f-th frame (0-based) within a run.
    function automatic logic [7:0] model_byte(input int f, input int idx);
        logic [111:0] hdr;
        logic [15:0]  seq;
        int           k;
        hdr = {DST, SRC, ET};
        seq = f[15:0];
        if (idx < ETH_HDR_LEN) return hdr[111 - 8*idx -: 8];
        k = idx - ETH_HDR_LEN;
`ifdef ETH_TX_GEN_SEQNUM_EN
        if (k == 0) return seq[15:8];
        if (k == 1) return seq[7:0];
`endif
        return 8'(k % 256);
    endfunction

    task automatic clear_capture();
        cap_d.delete();
        cap_l.delete();
        last_cyc.delete();
        start_cyc.delete();
        fs_after.delete();
        done_cyc      = -1;
        hs_last_prev  = 1'b0;
        stall_pending = 1'b0;
        prev_vld      = m_axis_tvalid;
    endtask

    // One clock: pick trdy, observe what the DUT presents at the coming edge, then advance.
    task automatic tick();
        case (rdy_mode)
            0:       m_axis_trdy = 1'b1;
            1:       m_axis_trdy = ~m_axis_trdy;
            default: m_axis_trdy = ($urandom_range(0, 3) != 0);
        endcase
        if (hs_last_prev) fs_after.push_back(o_frames_sent);
        if (stall_pending)
            check("axi_hold", 32'({m_axis_tdata, m_axis_tvalid, m_axis_tlast}), 32'(held));
        if (m_axis_tvalid && !prev_vld) start_cyc.push_back(cyc);
        if (o_done && done_cyc < 0) done_cyc = cyc;
        hs_last_prev = m_axis_tvalid && m_axis_trdy && m_axis_tlast;
        if (m_axis_tvalid && m_axis_trdy) begin
            cap_d.push_back(m_axis_tdata);
            cap_l.push_back(m_axis_tlast);
            if (m_axis_tlast) last_cyc.push_back(cyc);
        end
        stall_pending = m_axis_tvalid && !m_axis_trdy;
        held          = {m_axis_tdata, m_axis_tvalid, m_axis_tlast};
        prev_vld      = m_axis_tvalid;
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic run_until_done(input string tag, input int budget);
        for (int i = 0; i < budget && done_cyc < 0; i++) tick();
        check({tag, "_done_in_budget"}, 32'(done_cyc >= 0), 32'd1);
    endtask

    task automatic run_until_beats(input string tag, input int beats, input int budget);
        for (int i = 0; i < budget && cap_d.size() < beats; i++) tick();
        check({tag, "_beats_in_budget"}, 32'(cap_d.size()), 32'(beats));
    endtask

    task automatic verify_stream(input string tag, input int nframes);
        int n;
        check({tag, "_beat_count"}, 32'(cap_d.size()), 32'(nframes * FL));
        n = (cap_d.size() < nframes * FL) ? cap_d.size() : nframes * FL;
        for (int b = 0; b < n; b++)
            check($sformatf("%s_beat%0d", tag, b), 32'({cap_l[b], cap_d[b]}),
                  32'({((b % FL) == FL - 1), model_byte(b / FL, b % FL)}));
    endtask

    task automatic finish_run(input string tag);
        i_enable = 1'b0;
        tick();
        tick();
        check({tag, "_done_cleared"}, 32'(o_done), 32'd0);
        check({tag, "_busy_idle"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        i_reset       = 1'b1;
        i_enable      = 1'b0;
        i_frame_count = 16'd0;
        m_axis_trdy   = 1'b0;
        rdy_mode      = 0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_frames", 32'(o_frames_sent), 32'd0);
        i_reset = 1'b0;
        clear_capture();

        // Single frame, trdy held high
        i_frame_count = 16'd1;
        i_enable      = 1'b1;
        en_cyc        = cyc;
        run_until_beats("t1", 10, 50);
        check("t1_busy_mid_frame", 32'(o_busy), 32'd1);
        run_until_done("t1", 400);
        check("t1_first_valid_latency", 32'(start_cyc[0]), 32'(en_cyc + 2));
        verify_stream("t1", 1);
        check("t1_frames_sent", 32'(o_frames_sent), 32'd1);
        check("t1_frames_after_tlast", 32'(fs_after[0]), 32'd1);
        check("t1_done_timing", 32'(done_cyc), 32'(last_cyc[0] + GAP + 1));
        check("t1_busy_in_done", 32'(o_busy), 32'd0);
        finish_run("t1");

        // Single frame, trdy toggling
        clear_capture();
        rdy_mode      = 1;
        i_frame_count = 16'd1;
        i_enable      = 1'b1;
        run_until_done("t2", 600);
        verify_stream("t2", 1);
        finish_run("t2");

        // Three frames; a frame-count change while busy must be ignored
        clear_capture();
        rdy_mode      = 0;
        i_frame_count = 16'd3;
        i_enable      = 1'b1;
        repeat (5) tick();
        i_frame_count = 16'd1;
        run_until_done("t3", 1000);
        verify_stream("t3", 3);
        for (int i = 0; i < 2; i++)
            check($sformatf("t3_gap%0d", i), 32'(start_cyc[i + 1] - last_cyc[i] - 1), 32'(GAP));
        for (int i = 0; i < 3; i++)
            check($sformatf("t3_frames_step%0d", i), 32'(fs_after[i]), 32'(i + 1));
        check("t3_frames_sent", 32'(o_frames_sent), 32'd3);
        finish_run("t3");

        // Continuous run, enable dropped at beat 20
        clear_capture();
        i_frame_count = 16'd0;
        i_enable      = 1'b1;
        run_until_beats("t4", 20, 100);
        i_enable = 1'b0;
        repeat (FL + GAP + 40) tick();
        verify_stream("t4", 1);
        check("t4_no_done", 32'(done_cyc < 0), 32'd1);
        check("t4_busy", 32'(o_busy), 32'd0);
        check("t4_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("t4_frames_sent", 32'(o_frames_sent), 32'd1);

        // Reset at beat 30 of the second frame, then a fresh run under random back-pressure
        clear_capture();
        i_enable = 1'b1;
        run_until_beats("t5", FL + 30, 300);
        check("t5_frames_before_reset", 32'(o_frames_sent), 32'd1);
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        cyc++;
        check("t5_tvalid_after_reset", 32'(m_axis_tvalid), 32'd0);
        check("t5_frames_after_reset", 32'(o_frames_sent), 32'd0);
        check("t5_tlast_after_reset", 32'(m_axis_tlast), 32'd0);
        i_reset  = 1'b0;
        i_enable = 1'b0;
        tick();
        clear_capture();
        rdy_mode      = 2;
        i_frame_count = 16'd2;
        i_enable      = 1'b1;
        run_until_done("t5", 1500);
        verify_stream("t5", 2);
        finish_run("t5");

        // Random frame counts with random back-pressure
        for (int r = 0; r < 3; r++) begin
            int nf;
            nf = $urandom_range(1, 4);
            clear_capture();
            i_frame_count = 16'(nf);
            i_enable      = 1'b1;
            run_until_done($sformatf("rnd%0d", r), 3000);
            verify_stream($sformatf("rnd%0d", r), nf);
            check($sformatf("rnd%0d_frames_sent", r), 32'(o_frames_sent), 32'(nf));
            finish_run($sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
